// File: rtl/hdmi_tmds_link.sv
// Parallel TMDS link encoder: three 8b/10b TMDS video channels plus the clock channel.
// In HDMI mode, a look-ahead delay line places the video preamble and leading guard band ahead of active video.
module hdmi_tmds_link #(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned GUARD_LEN    = 2,
  parameter logic [9:0]  CLK_PATTERN  = 10'b0000011111,
  parameter bit          OUT_REG      = 1'b1
) (
  input  logic        pixel_clk_i,
  input  logic        rstn_i,
  input  logic [23:0] rgb_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        de_i,
  input  logic        hdmi_mode_i,
  output logic [39:0] symbols_o,
  output logic        de_o
);

  localparam int unsigned LA = PREAMBLE_LEN + GUARD_LEN;

  localparam logic [9:0] CTL_00 = 10'b1101010100;
  localparam logic [9:0] CTL_01 = 10'b0010101011;
  localparam logic [9:0] CTL_10 = 10'b0101010100;
  localparam logic [9:0] CTL_11 = 10'b1010101011;
  localparam logic [9:0] GRD_RB = 10'b1011001100;
  localparam logic [9:0] GRD_G  = 10'b0100110011;
  localparam logic [39:0] RST_SYM = {CLK_PATTERN, CTL_00, CTL_00, CTL_00};

  localparam logic [1:0] K_CTL = 2'd0;
  localparam logic [1:0] K_PRE = 2'd1;
  localparam logic [1:0] K_GRD = 2'd2;
  localparam logic [1:0] K_VID = 2'd3;

  function automatic logic [9:0] ctl_code(input logic [1:0] c);
    case (c)
      2'b00:   return CTL_00;
      2'b01:   return CTL_01;
      2'b10:   return CTL_10;
      default: return CTL_11;
    endcase
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(d[i]);
    return n;
  endfunction

  // Transition-minimising stage: XOR chain, inverted to XNOR for ones-heavy bytes
  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i] ^ use_xnor;
    q[8]     = ~use_xnor;
    return q;
  endfunction

  logic [LA-1:0] sr_de, sr_hs, sr_vs;
  logic [23:0]   sr_rgb [LA];

  // Look-ahead delay line; sr_*[LA-1] is the head
  always_ff @(posedge pixel_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sr_de <= '0;
      sr_hs <= '0;
      sr_vs <= '0;
      for (int unsigned i = 0; i < LA; i++) sr_rgb[i] <= '0;
    end else begin
      sr_de     <= {sr_de[LA-2:0], de_i};
      sr_hs     <= {sr_hs[LA-2:0], hsync_i};
      sr_vs     <= {sr_vs[LA-2:0], vsync_i};
      sr_rgb[0] <= rgb_i;
      for (int unsigned i = 1; i < LA; i++) sr_rgb[i] <= sr_rgb[i-1];
    end
  end

  logic [LA:1] look;
  logic        guard_hit, pre_hit;
  logic [1:0]  kind;

  // look[k] is de k cycles after the head; the newest tap is the live input
  always_comb begin
    look     = '0;
    look[LA] = de_i;
    for (int unsigned k = 1; k < LA; k++) look[k] = sr_de[LA-1-k];
    guard_hit = |look[GUARD_LEN:1];
    pre_hit   = |look[LA:GUARD_LEN+1];
    kind      = K_CTL;
    if (sr_de[LA-1])                   kind = K_VID;
    else if (hdmi_mode_i && guard_hit) kind = K_GRD;
    else if (hdmi_mode_i && pre_hit)   kind = K_PRE;
  end

  logic [1:0] s1_kind;
  logic       s1_hs, s1_vs;
  logic [8:0] s1_qm [3];

  always_ff @(posedge pixel_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_kind <= K_CTL;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      for (int unsigned c = 0; c < 3; c++) s1_qm[c] <= '0;
    end else begin
      s1_kind <= kind;
      s1_hs   <= sr_hs[LA-1];
      s1_vs   <= sr_vs[LA-1];
      for (int unsigned c = 0; c < 3; c++) s1_qm[c] <= tmds_qm(sr_rgb[LA-1][8*c +: 8]);
    end
  end

  logic [9:0]        sym_nxt [3];
  logic signed [4:0] cnt_nxt [3];
  logic signed [4:0] cnt     [3];
  logic [9:0]        s2_sym  [3];
  logic              s2_de;
  logic [3:0]        n1;
  logic signed [4:0] bal;
  logic              q8;

  // DC balancing; bal = N1-N0 of q_m[7:0], wrap-around 5-bit arithmetic is exact for |cnt| <= 8
  always_comb begin
    n1  = '0;
    bal = '0;
    q8  = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      sym_nxt[c] = CTL_00;
      cnt_nxt[c] = '0;
      n1  = ones8(s1_qm[c][7:0]);
      bal = $signed(5'({n1, 1'b0}) - 5'd8);
      q8  = s1_qm[c][8];
      case (s1_kind)
        K_VID: begin
          if ((cnt[c] == 5'sd0) || (n1 == 4'd4)) begin
            sym_nxt[c] = {~q8, q8, q8 ? s1_qm[c][7:0] : ~s1_qm[c][7:0]};
            cnt_nxt[c] = q8 ? (cnt[c] + bal) : (cnt[c] - bal);
          end else if (((cnt[c] > 5'sd0) && (n1 > 4'd4)) || ((cnt[c] < 5'sd0) && (n1 < 4'd4))) begin
            sym_nxt[c] = {1'b1, q8, ~s1_qm[c][7:0]};
            cnt_nxt[c] = cnt[c] - bal + (q8 ? 5'sd2 : 5'sd0);
          end else begin
            sym_nxt[c] = {1'b0, q8, s1_qm[c][7:0]};
            cnt_nxt[c] = cnt[c] + bal - (q8 ? 5'sd0 : 5'sd2);
          end
        end
        K_GRD:   sym_nxt[c] = (c == 1) ? GRD_G : GRD_RB;
        K_PRE:   sym_nxt[c] = (c == 0) ? ctl_code({s1_vs, s1_hs}) : ((c == 1) ? CTL_01 : CTL_00);
        default: sym_nxt[c] = (c == 0) ? ctl_code({s1_vs, s1_hs}) : CTL_00;
      endcase
    end
  end

  always_ff @(posedge pixel_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s2_de <= 1'b0;
      for (int unsigned c = 0; c < 3; c++) begin
        s2_sym[c] <= CTL_00;
        cnt[c]    <= '0;
      end
    end else begin
      s2_de <= (s1_kind == K_VID);
      for (int unsigned c = 0; c < 3; c++) begin
        s2_sym[c] <= sym_nxt[c];
        cnt[c]    <= cnt_nxt[c];
      end
    end
  end

  if (OUT_REG) begin : g_out_reg
    always_ff @(posedge pixel_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        symbols_o <= RST_SYM;
        de_o      <= 1'b0;
      end else begin
        symbols_o <= {CLK_PATTERN, s2_sym[2], s2_sym[1], s2_sym[0]};
        de_o      <= s2_de;
      end
    end
  end else begin : g_out_comb
    assign symbols_o = {CLK_PATTERN, s2_sym[2], s2_sym[1], s2_sym[0]};
    assign de_o      = s2_de;
  end

endmodule

// File: tb/tb_hdmi_tmds_link.sv
// Bench for hdmi_tmds_link: directed link scenarios checked against a cycle model and hand-computed symbols.
module tb_hdmi_tmds_link;

  localparam int GRD = 2;
  localparam int LA  = 10;
  localparam int L   = 13;
  localparam int N   = 2048;

  localparam logic [9:0] C00  = 10'b1101010100;
  localparam logic [9:0] C01  = 10'b0010101011;
  localparam logic [9:0] C10  = 10'b0101010100;
  localparam logic [9:0] C11  = 10'b1010101011;
  localparam logic [9:0] GRB  = 10'b1011001100;
  localparam logic [9:0] GG   = 10'b0100110011;
  localparam logic [9:0] CLKP = 10'b0000011111;
  localparam logic [9:0] V0   = 10'b0100000000;
  localparam logic [9:0] V1   = 10'b1111111111;
  localparam logic [39:0] RST = {CLKP, C00, C00, C00};

  logic        pixel_clk, rstn, de_in, hs, vs, mode;
  logic [23:0] rgb;
  logic [39:0] sym;
  logic        de_out;

  hdmi_tmds_link dut (
    .pixel_clk_i (pixel_clk),
    .rstn_i      (rstn),
    .rgb_i       (rgb),
    .hsync_i     (hs),
    .vsync_i     (vs),
    .de_i        (de_in),
    .hdmi_mode_i (mode),
    .symbols_o   (sym),
    .de_o        (de_out)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int tests, fails, cyc, zero_below;
  int cnt_m [3];
  int disp  [3];
  logic        h_de [N], h_hs [N], h_vs [N], h_mode [N];
  logic [23:0] h_rgb [N];
  logic [39:0] o_sym [N];
  logic        o_de  [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit live(input int j);
    return (j >= 0) && (j >= zero_below) && (j < cyc);
  endfunction

  function automatic logic [9:0] ctl(input logic [1:0] c);
    case (c)
      2'b00:   return C00;
      2'b01:   return C01;
      2'b10:   return C10;
      default: return C11;
    endcase
  endfunction

  function automatic logic [9:0] enc(input logic [7:0] d, input int c);
    int n1d, n1, n0;
    bit xn;
    logic [8:0] q;
    logic [9:0] r;
    n1d  = $countones(d);
    xn   = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    n1 = $countones(q[7:0]);
    n0 = 8 - n1;
    if (cnt_m[c] == 0 || n1 == n0) begin
      if (q[8]) begin r = {2'b01, q[7:0]};  cnt_m[c] += n1 - n0; end
      else      begin r = {2'b10, ~q[7:0]}; cnt_m[c] += n0 - n1; end
    end else if ((cnt_m[c] > 0 && n1 > n0) || (cnt_m[c] < 0 && n0 > n1)) begin
      r = {1'b1, q[8], ~q[7:0]};
      cnt_m[c] += 2 * int'(q[8]) + n0 - n1;
    end else begin
      r = {1'b0, q[8], q[7:0]};
      cnt_m[c] += n1 - n0 - (q[8] ? 0 : 2);
    end
    return r;
  endfunction

  // Expected {de, symbols} for the input of cycle j, with look-ahead over j+1..j+LA
  function automatic logic [40:0] golden(input int j);
    logic d, m, g, pr;
    logic [1:0] sync;
    logic [23:0] p;
    logic [9:0] ch [3];
    d    = live(j) ? h_de[j] : 1'b0;
    m    = live(j) ? h_mode[j] : 1'b0;
    sync = live(j) ? {h_vs[j], h_hs[j]} : 2'b00;
    p    = live(j) ? h_rgb[j] : 24'h0;
    g = 1'b0;
    pr = 1'b0;
    for (int k = 1; k <= GRD; k++)    g  |= live(j + k) ? h_de[j + k] : 1'b0;
    for (int k = GRD + 1; k <= LA; k++) pr |= live(j + k) ? h_de[j + k] : 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (d) ch[c] = enc(p[8*c +: 8], c);
      else begin
        cnt_m[c] = 0;
        if (m && g)       ch[c] = (c == 1) ? GG : GRB;
        else if (m && pr) ch[c] = (c == 0) ? ctl(sync) : ((c == 1) ? C01 : C00);
        else              ch[c] = (c == 0) ? ctl(sync) : C00;
      end
    end
    return {d, CLKP, ch[2], ch[1], ch[0]};
  endfunction

  task automatic step(input logic d, input logic h, input logic v, input logic [23:0] p);
    logic [40:0] e;
    int j;
    @(negedge pixel_clk);
    j = cyc - L;
    if (!rstn) begin
      check("rst_sym", sym, RST);
      check("rst_de", de_out, 1'b0);
    end else begin
      e = golden(j);
      check("sym", sym, e[39:0]);
      check("de", de_out, e[40]);
      if (j >= 0) begin
        o_sym[j] = sym;
        o_de[j]  = de_out;
      end
      for (int c = 0; c < 3; c++) begin
        if (de_out) begin
          disp[c] += 2 * $countones(sym[10*c +: 10]) - 10;
          check("disp", 64'(disp[c] >= -8 && disp[c] <= 8), 1);
        end else disp[c] = 0;
      end
    end
    de_in = d; hs = h; vs = v; rgb = p;
    h_de[cyc] = d; h_hs[cyc] = h; h_vs[cyc] = v; h_rgb[cyc] = p; h_mode[cyc] = mode;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic video(input int n);
    repeat (n) step(1'b1, 1'($urandom), 1'($urandom), 24'($urandom));
  endtask

  task automatic release_reset();
    rstn = 1'b1;
    zero_below = cyc - 1;
  endtask

  int rel, j2, j2v, j2b, t3, g0;

  initial begin
    tests = 0; fails = 0; cyc = 0; zero_below = 0;
    rstn = 1'b0; de_in = 1'b0; hs = 1'b0; vs = 1'b0; rgb = '0; mode = 1'b0;
    for (int c = 0; c < 3; c++) begin cnt_m[c] = 0; disp[c] = 0; end

    // reset held, then released into idle blanking
    idle(5);
    release_reset();
    rel = zero_below;
    idle(20);

    // DVI sync codes
    mode = 1'b0;
    j2 = cyc;  repeat (20) step(1'b0, 1'b1, 1'b0, 24'h0);
    j2v = cyc; repeat (5)  step(1'b0, 1'b0, 1'b1, 24'h0);
    j2b = cyc; repeat (5)  step(1'b0, 1'b1, 1'b1, 24'h0);
    idle(20);

    // HDMI: full preamble/guard, then a 5-cycle gap between lines
    mode = 1'b1;
    idle(20);
    t3 = cyc;
    repeat (16) step(1'b1, 1'b0, 1'b0, 24'h0);
    g0 = cyc;
    idle(5);
    repeat (16) step(1'b1, 1'b0, 1'b0, 24'h0);
    idle(20);

    // DVI random pixels
    mode = 1'b0;
    idle(20);
    video(1000);
    idle(20);

    // reset asserted mid-line
    mode = 1'b1;
    idle(15);
    video(20);
    check("mid_pre_de", de_out, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_sym", sym, RST);
    check("mid_rst_de", de_out, 1'b0);
    for (int c = 0; c < 3; c++) begin cnt_m[c] = 0; disp[c] = 0; end
    idle(3);
    release_reset();
    idle(15);
    video(20);
    idle(L + 5);

    check("t1_idle", o_sym[rel + 2], RST);
    check("t1_de", o_de[rel + 2], 1'b0);
    check("t2_before", o_sym[j2 - 1], {CLKP, C00, C00, C00});
    check("t2_hs", o_sym[j2], {CLKP, C00, C00, C01});
    check("t2_vs", o_sym[j2v], {CLKP, C00, C00, C10});
    check("t2_hsvs", o_sym[j2b], {CLKP, C00, C00, C11});
    check("t3_ctl", o_sym[t3 - 11], {CLKP, C00, C00, C00});
    for (int k = 10; k >= 3; k--) check("t3_pre", o_sym[t3 - k], {CLKP, C00, C01, C00});
    for (int k = 2; k >= 1; k--)  check("t3_grd", o_sym[t3 - k], {CLKP, GRB, GG, GRB});
    check("t3_de0", o_de[t3 - 1], 1'b0);
    check("t3_de1", o_de[t3], 1'b1);
    check("t3_v0", o_sym[t3], {CLKP, V0, V0, V0});
    check("t3_v1", o_sym[t3 + 1], {CLKP, V1, V1, V1});
    check("t3_v2", o_sym[t3 + 2], {CLKP, V0, V0, V0});
    check("t4_last_vid", o_de[g0 - 1], 1'b1);
    check("t4_gap_de", o_de[g0], 1'b0);
    for (int k = 0; k < 3; k++) check("t4_pre", o_sym[g0 + k], {CLKP, C00, C01, C00});
    for (int k = 3; k < 5; k++) check("t4_grd", o_sym[g0 + k], {CLKP, GRB, GG, GRB});
    check("t4_vid_de", o_de[g0 + 5], 1'b1);
    check("t4_vid_cnt0", o_sym[g0 + 5], {CLKP, V0, V0, V0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
